// File: rtl/rvmc_pkg.sv
// Shared encodings for the multicycle RV32I control path: state codes,
// opcodes and the datapath select/ALU operation encodings.
package rvmc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
      OP_BRANCH, OP_JAL, OP_LUI: is_legal_op = 1'b1;
      default:                   is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's ALUOp plus funct fields to ALUControl.
module aludec
  import rvmc_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl
);

  logic rtype_sub;

  // I-type has op[5]=0, so bit 30 of an immediate never turns addi into sub
  assign rtype_sub = funct7b5 & opb5;

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ALUControl = rtype_sub ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences instruction phases
// over the shared ALU and unified memory port.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  FETCH    | read instruction, PC <= PC+4 on MemReady
//  DECODE   | branch target into ALUOut, dispatch on op
//  MEMADR   | rs1 + imm effective address
//  MEMREAD  | load access, wait for MemReady
//  MEMWB    | write load data to rd
//  MEMWRITE | store access, wait for MemReady
//  EXECR    | rs1 op rs2
//  EXECI    | rs1 op imm
//  ALUWB    | write ALUOut to rd
//  BRANCH   | compare, PC <= target if taken
//  JAL      | PC <= target, OldPC+4 computed for rd
//  LUI      | 0 + imm
//  HALT     | parked after illegal op (trap mode), reset only
module multicycle_controller
  import rvmc_pkg::*;
#(
  parameter logic [3:0] RESET_STATE  = 4'd0,
  parameter bit         ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalOp
);

  state_t     state;
  logic [1:0] alu_op;
  logic       mem_req_d, mem_write_d, ir_write_d, pc_write_d;
  logic       reg_write_d, illegal_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= state_t'(RESET_STATE);
    end else begin
      case (state)
        S_FETCH:    if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_LUI:            state <= S_LUI;
            default:           state <= ILLEGAL_TRAP ? S_HALT : S_FETCH;
          endcase
        end
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (MemReady) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (MemReady) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_LUI:      state <= S_ALUWB;
        S_HALT:     state <= S_HALT;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req_d   = 1'b0;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    pc_write_d  = 1'b0;
    reg_write_d = 1'b0;
    illegal_d   = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    alu_op      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req_d  = 1'b1;
        ir_write_d = MemReady;
        pc_write_d = MemReady;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        illegal_d = ~is_legal_op(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req_d = 1'b1;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_d = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b1;
        AdrSrc      = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_d = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = SRCA_RD1;
        alu_op     = ALUOP_SUB;
        // funct3 000 = beq, 001 = bne; anything else never branches
        pc_write_d = (funct3[2:1] == 2'b00) & (Zero ^ funct3[0]);
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_write_d = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
      end
      default: ;
    endcase
  end

  // reset wins over any in-flight access, including a same-cycle MemReady
  assign MemReq    = mem_req_d   & ~reset;
  assign MemWrite  = mem_write_d & ~reset;
  assign IRWrite   = ir_write_d  & ~reset;
  assign PCWrite   = pc_write_d  & ~reset;
  assign RegWrite  = reg_write_d & ~reset;
  assign IllegalOp = illegal_d   & ~reset;

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      OP_LUI:    ImmSrc = IMM_U;
      default:   ImmSrc = IMM_I;
    endcase
  end

  aludec u_aludec (
    .opb5      (op[5]),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .ALUOp     (alu_op),
    .ALUControl(ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output vectors checked
// against hand-built expectations for each instruction class.
module tb_multicycle_controller;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, MemReady;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic [15:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller #(.RESET_STATE(4'd0), .ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .IllegalOp(IllegalOp)
  );

  // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,IllegalOp}
  assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, IllegalOp};

  localparam logic [15:0] F0      = 16'b100000_10_00_10_000_0;
  localparam logic [15:0] F1      = 16'b100110_10_00_10_000_0;
  localparam logic [15:0] DEC     = 16'b000000_00_01_01_000_0;
  localparam logic [15:0] DECI    = 16'b000000_00_01_01_000_1;
  localparam logic [15:0] MADR    = 16'b000000_00_10_01_000_0;
  localparam logic [15:0] MRD     = 16'b101000_00_00_00_000_0;
  localparam logic [15:0] MWB     = 16'b000001_01_00_00_000_0;
  localparam logic [15:0] MWR     = 16'b111000_00_00_00_000_0;
  localparam logic [15:0] AWB     = 16'b000001_00_00_00_000_0;
  localparam logic [15:0] JALV    = 16'b000010_00_01_10_000_0;
  localparam logic [15:0] LUIV    = 16'b000000_00_11_01_000_0;
  localparam logic [15:0] RST_F   = 16'b000000_10_00_10_000_0;
  localparam logic [15:0] RST_MWR = 16'b001000_00_00_00_000_0;

  function automatic logic [15:0] exr(input logic [2:0] ctl);
    exr = {6'b000000, 2'b00, 2'b10, 2'b00, ctl, 1'b0};
  endfunction
  function automatic logic [15:0] exi(input logic [2:0] ctl);
    exi = {6'b000000, 2'b00, 2'b10, 2'b01, ctl, 1'b0};
  endfunction
  function automatic logic [15:0] br(input logic pc);
    br = {4'b0000, pc, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rdy, input logic z);
    MemReady = rdy;
    Zero     = z;
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adv();
      n_checks++;
      if (obs !== RST_F) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs, RST_F);
      end
    end
    reset = 1'b0;
    drive(1'b0, 1'b0);
    n_checks++;
    if (obs !== F0) begin
      n_fail++;
      $display("FAIL reset_release_wait: got %b expected %b", obs, F0);
    end
    drive(1'b1, 1'b0);
    n_checks++;
    if (obs !== F1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected %b", obs, F1);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_lw();
    logic [15:0] ev [9];
    logic        rd [9];
    ev = '{F0, F0, F1, DEC, MADR, MRD, MRD, MWB, F0};
    rd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(rd[i], 1'b0);
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL lw step %0d: got %b expected %b", i, obs, ev[i]);
      end
      if (i == 3) begin
        n_checks++;
        if (ImmSrc !== 3'b000) begin
          n_fail++;
          $display("FAIL lw_immsrc: got %b expected 000", ImmSrc);
        end
      end
      if (i < 8) adv();
    end
  endtask

  task automatic test_sw();
    logic [15:0] ev [5];
    ev = '{F1, DEC, MADR, MWR, F0};
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, 1'b0);
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL sw step %0d: got %b expected %b", i, obs, ev[i]);
      end
      if (i == 1) begin
        n_checks++;
        if (ImmSrc !== 3'b001) begin
          n_fail++;
          $display("FAIL sw_immsrc: got %b expected 001", ImmSrc);
        end
      end
      if (i < 4) adv();
    end
  endtask

  task automatic test_alu();
    logic [6:0]  ops [5];
    logic [2:0]  f3s [5];
    logic        f7s [5];
    logic [15:0] mid [5];
    ops = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011, 7'b0110011};
    f3s = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b010};
    f7s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    mid = '{exr(3'b001), exr(3'b000), exi(3'b000), exr(3'b011), exr(3'b101)};
    for (int k = 0; k < 5; k++) begin
      logic [15:0] ev [5];
      ev = '{F1, DEC, mid[k], AWB, F0};
      op = ops[k]; funct3 = f3s[k]; funct7b5 = f7s[k];
      for (int i = 0; i < 5; i++) begin
        drive(i == 0, 1'b0);
        n_checks++;
        if (obs !== ev[i]) begin
          n_fail++;
          $display("FAIL alu case %0d step %0d: got %b expected %b", k, i, obs, ev[i]);
        end
        if (i < 4) adv();
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [5];
    logic       zs  [5];
    logic       pcs [5];
    f3s = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b100};
    zs  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    pcs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    op = 7'b1100011; funct7b5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [15:0] ev [4];
      ev = '{F1, DEC, br(pcs[k]), F0};
      funct3 = f3s[k];
      for (int i = 0; i < 4; i++) begin
        drive(i == 0, zs[k]);
        n_checks++;
        if (obs !== ev[i]) begin
          n_fail++;
          $display("FAIL branch case %0d step %0d: got %b expected %b", k, i, obs, ev[i]);
        end
        if (i == 1) begin
          n_checks++;
          if (ImmSrc !== 3'b010) begin
            n_fail++;
            $display("FAIL branch_immsrc: got %b expected 010", ImmSrc);
          end
        end
        if (i < 3) adv();
      end
    end
  endtask

  task automatic test_jal_lui();
    logic [6:0]  ops [2];
    logic [15:0] mid [2];
    logic [2:0]  imm [2];
    ops = '{7'b1101111, 7'b0110111};
    mid = '{JALV, LUIV};
    imm = '{3'b011, 3'b100};
    funct3 = 3'b000; funct7b5 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      logic [15:0] ev [5];
      ev = '{F1, DEC, mid[k], AWB, F0};
      op = ops[k];
      for (int i = 0; i < 5; i++) begin
        drive(i == 0, 1'b0);
        n_checks++;
        if (obs !== ev[i]) begin
          n_fail++;
          $display("FAIL jal_lui case %0d step %0d: got %b expected %b", k, i, obs, ev[i]);
        end
        if (i == 1) begin
          n_checks++;
          if (ImmSrc !== imm[k]) begin
            n_fail++;
            $display("FAIL jal_lui_immsrc case %0d: got %b expected %b", k, ImmSrc, imm[k]);
          end
        end
        if (i < 4) adv();
      end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] ev [3];
    ev = '{F1, DECI, F0};
    op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1'b0);
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL illegal step %0d: got %b expected %b", i, obs, ev[i]);
      end
      if (i < 2) adv();
    end
  endtask

  task automatic test_reset_midaccess();
    logic [15:0] ev [3];
    ev = '{F1, DEC, MADR};
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1'b0);
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL midreset step %0d: got %b expected %b", i, obs, ev[i]);
      end
      adv();
    end
    reset = 1'b1;
    drive(1'b1, 1'b0);
    n_checks++;
    if (obs !== RST_MWR) begin
      n_fail++;
      $display("FAIL midreset_memwrite: got %b expected %b", obs, RST_MWR);
    end
    adv();
    reset = 1'b0;
    drive(1'b0, 1'b0);
    n_checks++;
    if (obs !== F0) begin
      n_fail++;
      $display("FAIL midreset_fetch: got %b expected %b", obs, F0);
    end
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; MemReady = 1'b0;
    test_reset();
    test_lw();
    test_sw();
    test_alu();
    test_branch();
    test_jal_lui();
    test_illegal();
    test_reset_midaccess();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM for the multicycle RV32I core, which shares one ALU and one instruction/data memory port across instruction phases.
- Sequences fetch, decode, execute, memory and writeback per instruction.
- Drives the datapath mux selects and write enables.
- Handshakes with the unified memory port through MemReq/MemReady.
- Decodes lw, sw, R-type, I-type ALU, beq, bne, jal and lui.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.
- ILLEGAL_TRAP, 0: 0 = illegal opcode returns to FETCH after an IllegalOp pulse; 1 = FSM parks in HALT until reset.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  7  instruction opcode, from instruction register
- funct3  in  3  instruction funct3, from IR
- funct7b5  in  1  instruction bit 30, from IR
- Zero  in  1  ALU zero flag, combinational in the current cycle
- MemReady  in  1  memory completes the current access this cycle
- MemReq  out  1  memory access request
- MemWrite  out  1  store strobe, qualified by MemReq
- AdrSrc  out  1  address select: 0 = PC, 1 = Result
- IRWrite  out  1  load instruction register and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- IllegalOp  out  1  one-cycle pulse on an undecodable opcode

Behaviour:
- Machine type: Moore FSM with a 4-bit state register.
  - Exceptions: PCWrite and IRWrite are gated by MemReady or Zero.
  - ImmSrc is a pure combinational function of op.
- Reset: while reset=1, MemReq, MemWrite, IRWrite, PCWrite, RegWrite and IllegalOp are forced to 0. The next edge loads RESET_STATE; the first cycle after release is FETCH.
- Default output values in every state: all strobes 0, selects 00, ALUOp 00.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE on MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other op: IllegalOp=1 this cycle, then FETCH (or HALT if ILLEGAL_TRAP=1).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMWRITE if op[5]=1, else MEMREAD.
- MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Wait for MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Wait for MemReady, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = Zero XOR funct3[0] (beq/bne).
  - funct3 values other than 000/001 give PCWrite=0.
  - Next state: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB (rd = OldPC+4).
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00, then ALUWB.
- HALT: all strobes 0; exit only on reset.
- ALUControl: ALUOp -> ALUControl via aludec. R-type sub is selected when funct7b5 & op[5]; I-type never subtracts.
- Latency with zero memory wait:
  - 3 cycles: beq, bne
  - 4 cycles: sw, R-type, I-type, jal, lui
  - 5 cycles: lw
  - Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset mid-access: reset beats MemReady. The strobes drop in the same cycle reset is sampled high, and no RegWrite, PCWrite or IRWrite occurs.
- Unused state codes decode to FETCH on the next edge with all strobes 0.

Decomposition:
- Package rvmc_pkg holds shared constants:
  - state codes
  - opcode constants
  - ResultSrc, ALUSrcA, ALUSrcB, ImmSrc and ALUOp encodings
- Sub-modules:
  - Instantiate the existing aludec unchanged for ALUControl.
  - Immediate-format decode is a small case on op inside this block.

Test Plan:
- Reset held 3 cycles while MemReady=1 -> all strobes 0; after release, FETCH with MemReq=1 and IRWrite=PCWrite=1.
- lw with MemReady low for 2 cycles in FETCH and 1 in MEMREAD -> 8 total cycles; RegWrite with ResultSrc=01 for exactly one cycle.
- sw with MemReady=1 -> 4 cycles; MemWrite=1 only in cycle 4 with AdrSrc=1; RegWrite never asserted.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; add (funct7b5=0) -> 000; I-type addi with funct7b5=1 -> 000.
- beq with Zero=1 -> PCWrite=1 in BRANCH; bne with Zero=1 -> PCWrite=0; both paths take 3 cycles.
- op=1111111 -> IllegalOp one-cycle pulse in DECODE, then FETCH (ILLEGAL_TRAP=0); reset asserted in MEMWRITE with MemReady=1 -> MemWrite=0 that cycle, then FETCH.
